// File: rtl/inst_queue.sv
// Registered instruction FIFO between fetch and decode/dispatch; squash flushes all entries.
// Optional macro INST_QUEUE_BYPASS_EN: an empty queue forwards if_packet to dp_packet in the same cycle.
package inst_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_DP_PACKET;
endpackage

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             if_valid,
  input  IF_DP_PACKET      if_packet,
  output logic             iq_ready,
  input  logic             dp_stall,
  output IF_DP_PACKET      dp_packet,
  output logic [CNT_W-1:0] iq_count,
  output logic             iq_empty,
  output logic             iq_full
);

  localparam int PTR_W = $clog2(DEPTH);

  IF_DP_PACKET      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, bypass;
  IF_DP_PACKET      wr_pkt, head_pkt;

  assign iq_count = count_q;
  assign iq_empty = (count_q == '0);
  assign iq_full  = (count_q == CNT_W'(DEPTH));
  assign iq_ready = ~iq_full;

  // Stored entries carry valid=1 so the head needs no separate valid override.
  always_comb begin
    wr_pkt       = if_packet;
    wr_pkt.valid = 1'b1;
  end

`ifdef INST_QUEUE_BYPASS_EN
  assign bypass = iq_empty & if_valid & ~dp_stall & ~squash;
`else
  assign bypass = 1'b0;
`endif

  assign push = if_valid & iq_ready & ~squash & ~bypass;
  assign pop  = ~iq_empty & ~dp_stall & ~squash;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[tail_q] <= wr_pkt;
  end

  // Empty queue presents an all-zero NOP to the decoder.
  assign head_pkt = iq_empty ? '0 : mem_q[head_q];

`ifdef INST_QUEUE_BYPASS_EN
  assign dp_packet = bypass ? wr_pkt : head_pkt;
`else
  assign dp_packet = head_pkt;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: driver queues expected PCs, a monitor checks against an occupancy model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             squash;
  logic             if_valid;
  IF_DP_PACKET      if_packet;
  logic             iq_ready;
  logic             dp_stall;
  IF_DP_PACKET      dp_packet;
  logic [CNT_W-1:0] iq_count;
  logic             iq_empty;
  logic             iq_full;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cnt_m  = 0;
  int          n_deliv = 0;
  logic [31:0] exp_q[$];
  logic        done = 1'b0;

  inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .squash   (squash),
    .if_valid (if_valid),
    .if_packet(if_packet),
    .iq_ready (iq_ready),
    .dp_stall (dp_stall),
    .dp_packet(dp_packet),
    .iq_count (iq_count),
    .iq_empty (iq_empty),
    .iq_full  (iq_full)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reference model is an occupancy count plus the ordered list of issued PCs.
  initial forever begin
    logic pop_m, push_m, byp_m;
    @(negedge clock);
    if (reset) begin
      cnt_m = 0;
      exp_q.delete();
      done = 1'b0;
    end else begin
      byp_m = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      byp_m = (cnt_m == 0) && if_valid && !dp_stall && !squash;
`endif
      check("count", 32'(iq_count), 32'(cnt_m));
      check("empty", 32'(iq_empty), 32'(cnt_m == 0));
      check("full",  32'(iq_full),  32'(cnt_m == DEPTH));
      check("ready", 32'(iq_ready), 32'(cnt_m < DEPTH));
      if (byp_m) begin
        check("byp_valid", 32'(dp_packet.valid), 32'd1);
        if (exp_q.size() == 0) check("model_sync", 32'd0, 32'd1);
        else begin
          check("byp_pc", dp_packet.PC, exp_q[0]);
          void'(exp_q.pop_front());
        end
        n_deliv++;
        done = 1'b1;
      end else begin
        check("valid", 32'(dp_packet.valid), 32'(cnt_m > 0));
        if (cnt_m == 0) check("nop_pkt", 32'(dp_packet == '0), 32'd1);
        else if (exp_q.size() == 0) check("model_sync", 32'd0, 32'd1);
        else check("head_pc", dp_packet.PC, exp_q[0]);
        pop_m  = (cnt_m > 0) && !dp_stall && !squash;
        push_m = if_valid && !squash && (cnt_m < DEPTH);
        if (squash) begin
          cnt_m = 0;
          exp_q.delete();
          done = 1'b1;
        end else begin
          if (pop_m) begin
            void'(exp_q.pop_front());
            cnt_m--;
            n_deliv++;
          end
          if (push_m) cnt_m++;
          done = push_m;
        end
      end
    end
  end

  task automatic present(input logic [31:0] pc);
    if_packet = '{valid: 1'($urandom), inst: $urandom, PC: pc, NPC: pc + 32'd4};
    if_valid  = 1'b1;
    exp_q.push_back(pc);
  endtask

  // Called at posedge+1; returns at posedge+1 after the packet is taken.
  task automatic send(input logic [31:0] pc, input bit rnd);
    int w;
    present(pc);
    for (w = 0; w < 60; w++) begin
      if (rnd) dp_stall = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      if (done) break;
    end
    check("send_timeout", 32'(w < 60), 32'd1);
    if_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drain();
    int w;
    if_valid = 1'b0;
    dp_stall = 1'b0;
    for (w = 0; w < 100; w++) begin
      if (cnt_m == 0 && exp_q.size() == 0) break;
      @(posedge clock); #1;
    end
    check("drain_timeout", 32'(w < 100), 32'd1);
  endtask

  initial begin
    int d0;
    reset = 1'b1; squash = 1'b0; if_valid = 1'b0; dp_stall = 1'b0; if_packet = '0;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Reset mid-stream
    dp_stall = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h10 + 32'(i * 4), 1'b0);
    check("pre_rst_count", 32'(iq_count), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("rst_count", 32'(iq_count), 32'd0);
    check("rst_valid", 32'(dp_packet.valid), 32'd0);
    check("rst_ready", 32'(iq_ready), 32'd1);
    check("rst_empty", 32'(iq_empty), 32'd1);
    @(posedge clock); #1 reset = 1'b0;
    idle(1);

    // Fill to full, then full with simultaneous pop
    dp_stall = 1'b1;
    for (int i = 0; i < 8; i++) send(32'(i * 4), 1'b0);
    check("fill_count", 32'(iq_count), 32'd8);
    present(32'h20);
    @(posedge clock); #1;
    check("full_reject", 32'(done), 32'd0);
    check("full_count", 32'(iq_count), 32'd8);
    dp_stall = 1'b0;
    @(posedge clock); #1;
    check("full_pop_reject", 32'(done), 32'd0);
    check("full_pop_count", 32'(iq_count), 32'd7);
    @(posedge clock); #1;
    check("retry_accept", 32'(done), 32'd1);
    check("retry_count", 32'(iq_count), 32'd7);
    drain();

    // Wrap and order under random stalls
    d0 = n_deliv;
    for (int i = 0; i < 20; i++) begin
      send(32'h100 + 32'(i * 4), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        dp_stall = 1'($urandom_range(0, 1));
        idle($urandom_range(1, 2));
      end
    end
    drain();
    check("wrap_delivered", 32'(n_deliv - d0), 32'd20);

    // Squash with concurrent push and pop
    dp_stall = 1'b1;
    for (int i = 0; i < 5; i++) send(32'h300 + 32'(i * 4), 1'b0);
    d0 = n_deliv;
    present(32'h400);
    dp_stall = 1'b0;
    squash   = 1'b1;
    @(posedge clock); #1;
    squash   = 1'b0;
    if_valid = 1'b0;
    check("sq_count", 32'(iq_count), 32'd0);
    check("sq_valid", 32'(dp_packet.valid), 32'd0);
    idle(2);
    check("sq_no_deliver", 32'(n_deliv - d0), 32'd0);

    // Empty-queue latency (bypass or one cycle)
    dp_stall = 1'b0;
    present(32'h200);
    #2;
`ifdef INST_QUEUE_BYPASS_EN
    check("byp_same_valid", 32'(dp_packet.valid), 32'd1);
    check("byp_same_pc", dp_packet.PC, 32'h200);
    check("byp_same_count", 32'(iq_count), 32'd0);
    @(posedge clock); #1;
    if_valid = 1'b0;
    check("byp_after_count", 32'(iq_count), 32'd0);
`else
    check("lat_same_valid", 32'(dp_packet.valid), 32'd0);
    @(posedge clock); #1;
    if_valid = 1'b0;
    check("lat_next_valid", 32'(dp_packet.valid), 32'd1);
    check("lat_next_pc", dp_packet.PC, 32'h200);
    check("lat_next_count", 32'(iq_count), 32'd1);
`endif
    drain();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
